// File: rtl/riscv_dmem_arbiter.sv
// Two-port arbiter in front of the dcache request port: LSU (port 0) and aux (port 1).
// A small in-order source FIFO steers each response back to the port that issued it.
module riscv_dmem_arbiter #(
   parameter int unsigned OUTSTANDING  = 4,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [31:0]                    lsu_mem_addr_i,
   input  logic [31:0]                    lsu_mem_data_wr_i,
   input  logic                           lsu_mem_rd_i,
   input  logic [3:0]                     lsu_mem_wr_i,
   input  logic                           lsu_mem_cacheable_i,
   input  logic [10:0]                    lsu_mem_req_tag_i,
   input  logic                           lsu_mem_invalidate_i,
   input  logic                           lsu_mem_flush_i,
   output logic                           lsu_mem_accept_o,
   output logic                           lsu_mem_ack_o,
   output logic                           lsu_mem_error_o,
   output logic [10:0]                    lsu_mem_resp_tag_o,
   output logic [31:0]                    lsu_mem_data_rd_o,
   input  logic [31:0]                    aux_mem_addr_i,
   input  logic [31:0]                    aux_mem_data_wr_i,
   input  logic                           aux_mem_rd_i,
   input  logic [3:0]                     aux_mem_wr_i,
   input  logic                           aux_mem_cacheable_i,
   input  logic [10:0]                    aux_mem_req_tag_i,
   input  logic                           aux_mem_invalidate_i,
   input  logic                           aux_mem_flush_i,
   output logic                           aux_mem_accept_o,
   output logic                           aux_mem_ack_o,
   output logic                           aux_mem_error_o,
   output logic [10:0]                    aux_mem_resp_tag_o,
   output logic [31:0]                    aux_mem_data_rd_o,
   output logic [31:0]                    mem_addr_o,
   output logic [31:0]                    mem_data_wr_o,
   output logic                           mem_rd_o,
   output logic [3:0]                     mem_wr_o,
   output logic                           mem_cacheable_o,
   output logic [10:0]                    mem_req_tag_o,
   output logic                           mem_invalidate_o,
   output logic                           mem_flush_o,
   input  logic                           mem_accept_i,
   input  logic                           mem_ack_i,
   input  logic                           mem_error_i,
   input  logic [10:0]                    mem_resp_tag_i,
   input  logic [31:0]                    mem_data_rd_i,
   output logic [$clog2(OUTSTANDING):0]   outstanding_o,
   output logic                           err_unexpected_o
);

   localparam int unsigned PtrW = $clog2(OUTSTANDING);
   localparam int unsigned CntW = $clog2(OUTSTANDING) + 1;
   localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]        count_q, count_d;
   logic [OUTSTANDING-1:0] src_q, src_d;
   logic                   lock_q, lock_d, lock_src_q, lock_src_d;
   logic [StW-1:0]         starve_q, starve_d;
   logic                   err_q, err_d;

   logic req0, req1, gnt_valid, gnt_aux, fifo_full, present, push, pop, head_aux;

   assign req0 = lsu_mem_rd_i | (|lsu_mem_wr_i) | lsu_mem_invalidate_i | lsu_mem_flush_i;
   assign req1 = aux_mem_rd_i | (|aux_mem_wr_i) | aux_mem_invalidate_i | aux_mem_flush_i;
   assign fifo_full = (count_q == CntW'(OUTSTANDING));

   // Reset gates the combinational paths so every output is 0 while rst_ni is low.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_aux   = 1'b0;
      if (!rst_ni) begin
         gnt_valid = 1'b0;
      end else if (lock_q) begin
         gnt_valid = 1'b1;
         gnt_aux   = lock_src_q;
      end else if (req1 && (!req0 || starve_q == StW'(STARVE_LIMIT))) begin
         gnt_valid = 1'b1;
         gnt_aux   = 1'b1;
      end else if (req0) begin
         gnt_valid = 1'b1;
      end
   end

   assign present          = gnt_valid & ~fifo_full;
   assign push             = present & mem_accept_i;
   assign lsu_mem_accept_o = push & ~gnt_aux;
   assign aux_mem_accept_o = push & gnt_aux;
   assign pop              = rst_ni & mem_ack_i & (count_q != '0);
   assign head_aux         = src_q[rd_ptr_q];

   always_comb begin
      mem_addr_o       = '0;
      mem_data_wr_o    = '0;
      mem_rd_o         = 1'b0;
      mem_wr_o         = '0;
      mem_cacheable_o  = 1'b0;
      mem_req_tag_o    = '0;
      mem_invalidate_o = 1'b0;
      mem_flush_o      = 1'b0;
      if (present && gnt_aux) begin
         mem_addr_o       = aux_mem_addr_i;
         mem_data_wr_o    = aux_mem_data_wr_i;
         mem_rd_o         = aux_mem_rd_i;
         mem_wr_o         = aux_mem_wr_i;
         mem_cacheable_o  = aux_mem_cacheable_i;
         mem_req_tag_o    = aux_mem_req_tag_i;
         mem_invalidate_o = aux_mem_invalidate_i;
         mem_flush_o      = aux_mem_flush_i;
      end else if (present) begin
         mem_addr_o       = lsu_mem_addr_i;
         mem_data_wr_o    = lsu_mem_data_wr_i;
         mem_rd_o         = lsu_mem_rd_i;
         mem_wr_o         = lsu_mem_wr_i;
         mem_cacheable_o  = lsu_mem_cacheable_i;
         mem_req_tag_o    = lsu_mem_req_tag_i;
         mem_invalidate_o = lsu_mem_invalidate_i;
         mem_flush_o      = lsu_mem_flush_i;
      end
   end

   always_comb begin
      lsu_mem_ack_o      = 1'b0;
      lsu_mem_error_o    = 1'b0;
      lsu_mem_resp_tag_o = '0;
      lsu_mem_data_rd_o  = '0;
      aux_mem_ack_o      = 1'b0;
      aux_mem_error_o    = 1'b0;
      aux_mem_resp_tag_o = '0;
      aux_mem_data_rd_o  = '0;
      if (pop && head_aux) begin
         aux_mem_ack_o      = 1'b1;
         aux_mem_error_o    = mem_error_i;
         aux_mem_resp_tag_o = mem_resp_tag_i;
         aux_mem_data_rd_o  = mem_data_rd_i;
      end else if (pop) begin
         lsu_mem_ack_o      = 1'b1;
         lsu_mem_error_o    = mem_error_i;
         lsu_mem_resp_tag_o = mem_resp_tag_i;
         lsu_mem_data_rd_o  = mem_data_rd_i;
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      src_d      = src_q;
      lock_d     = lock_q;
      lock_src_d = lock_src_q;
      starve_d   = starve_q;
      err_d      = err_q | (rst_ni & mem_ack_i & (count_q == '0));
      if (push) begin
         src_d[wr_ptr_q] = gnt_aux;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CntW'(1);
      end
      // Hold the grant on a presented-but-stalled request so its fields stay stable.
      if (present) begin
         lock_d     = ~mem_accept_i;
         lock_src_d = mem_accept_i ? lock_src_q : gnt_aux;
      end
      if (!req1 || aux_mem_accept_o) begin
         starve_d = '0;
      end else if (lsu_mem_accept_o && starve_q != StW'(STARVE_LIMIT)) begin
         starve_d = starve_q + StW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         src_q      <= '0;
         lock_q     <= 1'b0;
         lock_src_q <= 1'b0;
         starve_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         src_q      <= src_d;
         lock_q     <= lock_d;
         lock_src_q <= lock_src_d;
         starve_q   <= starve_d;
         err_q      <= err_d;
      end
   end

   assign outstanding_o    = count_q;
   assign err_unexpected_o = err_q;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Directed bench for riscv_dmem_arbiter: inputs change 1ns after posedge, outputs are
// sampled on the falling edge.
module tb_riscv_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] lsu_addr, lsu_wdata, aux_addr, aux_wdata;
   logic        lsu_rd, aux_rd, lsu_cach, aux_cach, lsu_inv, aux_inv, lsu_fl, aux_fl;
   logic [3:0]  lsu_wr, aux_wr;
   logic [10:0] lsu_tag, aux_tag;
   logic        lsu_acc, aux_acc, lsu_ack, aux_ack, lsu_err, aux_err;
   logic [10:0] lsu_rtag, aux_rtag;
   logic [31:0] lsu_rdata, aux_rdata;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        m_rd, m_cach, m_inv, m_fl, m_accept, m_ack, m_error;
   logic [3:0]  m_wr;
   logic [10:0] m_tag, m_rtag;
   logic [2:0]  outstanding;
   logic        err_unexp;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   riscv_dmem_arbiter #(.OUTSTANDING(4), .STARVE_LIMIT(3)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .lsu_mem_addr_i(lsu_addr), .lsu_mem_data_wr_i(lsu_wdata), .lsu_mem_rd_i(lsu_rd),
      .lsu_mem_wr_i(lsu_wr), .lsu_mem_cacheable_i(lsu_cach), .lsu_mem_req_tag_i(lsu_tag),
      .lsu_mem_invalidate_i(lsu_inv), .lsu_mem_flush_i(lsu_fl),
      .lsu_mem_accept_o(lsu_acc), .lsu_mem_ack_o(lsu_ack), .lsu_mem_error_o(lsu_err),
      .lsu_mem_resp_tag_o(lsu_rtag), .lsu_mem_data_rd_o(lsu_rdata),
      .aux_mem_addr_i(aux_addr), .aux_mem_data_wr_i(aux_wdata), .aux_mem_rd_i(aux_rd),
      .aux_mem_wr_i(aux_wr), .aux_mem_cacheable_i(aux_cach), .aux_mem_req_tag_i(aux_tag),
      .aux_mem_invalidate_i(aux_inv), .aux_mem_flush_i(aux_fl),
      .aux_mem_accept_o(aux_acc), .aux_mem_ack_o(aux_ack), .aux_mem_error_o(aux_err),
      .aux_mem_resp_tag_o(aux_rtag), .aux_mem_data_rd_o(aux_rdata),
      .mem_addr_o(m_addr), .mem_data_wr_o(m_wdata), .mem_rd_o(m_rd), .mem_wr_o(m_wr),
      .mem_cacheable_o(m_cach), .mem_req_tag_o(m_tag), .mem_invalidate_o(m_inv),
      .mem_flush_o(m_fl), .mem_accept_i(m_accept), .mem_ack_i(m_ack), .mem_error_i(m_error),
      .mem_resp_tag_i(m_rtag), .mem_data_rd_i(m_rdata),
      .outstanding_o(outstanding), .err_unexpected_o(err_unexp)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      lsu_addr = '0; lsu_wdata = '0; lsu_rd = 0; lsu_wr = '0; lsu_cach = 0; lsu_tag = '0;
      lsu_inv = 0; lsu_fl = 0;
      aux_addr = '0; aux_wdata = '0; aux_rd = 0; aux_wr = '0; aux_cach = 0; aux_tag = '0;
      aux_inv = 0; aux_fl = 0;
      m_accept = 0; m_ack = 0; m_error = 0; m_rtag = '0; m_rdata = '0;
   endtask

   task automatic test_reset();
      lsu_rd = 1; lsu_addr = 32'h55; m_accept = 1;
      settle();
      checks++; if (m_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %0h want 0", m_rd); end
      checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %0h want 0", m_addr); end
      checks++; if (lsu_acc !== 1'b0) begin errors++; $display("FAIL reset_acc: got %0h want 0", lsu_acc); end
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", outstanding); end
      checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL reset_err: got %0h want 0", err_unexp); end
      tick();
      clear_inputs();
      rst_n = 1;
   endtask

   task automatic test_single_read();
      lsu_rd = 1; lsu_addr = 32'h100; lsu_tag = 11'h205; m_accept = 1;
      settle();
      checks++; if (m_rd !== 1'b1) begin errors++; $display("FAIL single_rd: got %0h want 1", m_rd); end
      checks++; if (m_addr !== 32'h100) begin errors++; $display("FAIL single_addr: got %0h want 100", m_addr); end
      checks++; if (m_tag !== 11'h205) begin errors++; $display("FAIL single_tag: got %0h want 205", m_tag); end
      checks++; if (lsu_acc !== 1'b1 || aux_acc !== 1'b0) begin errors++; $display("FAIL single_acc: got %0b%0b want 01", aux_acc, lsu_acc); end
      tick();
      lsu_rd = 0; m_ack = 1; m_rdata = 32'hDEADBEEF; m_rtag = 11'h205;
      settle();
      checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_cnt1: got %0d want 1", outstanding); end
      checks++; if (lsu_ack !== 1'b1 || aux_ack !== 1'b0) begin errors++; $display("FAIL single_ack: got %0b%0b want 01", aux_ack, lsu_ack); end
      checks++; if (lsu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %0h want deadbeef", lsu_rdata); end
      checks++; if (lsu_rtag !== 11'h205) begin errors++; $display("FAIL single_rtag: got %0h want 205", lsu_rtag); end
      checks++; if (aux_rdata !== 32'h0) begin errors++; $display("FAIL single_auxdata: got %0h want 0", aux_rdata); end
      tick();
      m_ack = 0;
      settle();
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_cnt0: got %0d want 0", outstanding); end
      tick();
   endtask

   task automatic test_starvation();
      logic [7:0] exp_aux = 8'b1000_1000;
      lsu_rd = 1; lsu_addr = 32'h1000; aux_rd = 1; aux_addr = 32'h2000; m_accept = 1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) m_ack = 1;
         settle();
         checks++;
         if (aux_acc !== exp_aux[i] || lsu_acc !== !exp_aux[i]) begin
            errors++; $display("FAIL starve_grant[%0d]: got aux=%0b lsu=%0b want aux=%0b", i, aux_acc, lsu_acc, exp_aux[i]);
         end
         checks++;
         if (m_addr !== (exp_aux[i] ? 32'h2000 : 32'h1000)) begin
            errors++; $display("FAIL starve_addr[%0d]: got %0h", i, m_addr);
         end
         tick();
      end
      lsu_rd = 0; aux_rd = 0;
      tick();
      m_ack = 0;
      settle();
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL starve_drain: got %0d want 0", outstanding); end
      tick();
   endtask

   task automatic test_lock();
      clear_inputs();
      aux_rd = 1; aux_addr = 32'h3000; aux_tag = 11'h055;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin lsu_rd = 1; lsu_addr = 32'h4000; lsu_tag = 11'h066; end
         settle();
         checks++;
         if (m_addr !== 32'h3000 || m_tag !== 11'h055 || m_rd !== 1'b1) begin
            errors++; $display("FAIL lock_hold[%0d]: got addr=%0h tag=%0h rd=%0b want 3000/055/1", i, m_addr, m_tag, m_rd);
         end
         checks++;
         if (aux_acc !== 1'b0 || lsu_acc !== 1'b0) begin
            errors++; $display("FAIL lock_noacc[%0d]: got aux=%0b lsu=%0b want 0", i, aux_acc, lsu_acc);
         end
         tick();
      end
      m_accept = 1;
      settle();
      checks++; if (aux_acc !== 1'b1 || lsu_acc !== 1'b0) begin errors++; $display("FAIL lock_release: got aux=%0b lsu=%0b want aux", aux_acc, lsu_acc); end
      tick();
      aux_rd = 0;
      settle();
      checks++; if (lsu_acc !== 1'b1 || m_addr !== 32'h4000) begin errors++; $display("FAIL lock_next: got acc=%0b addr=%0h want 1/4000", lsu_acc, m_addr); end
      tick();
      lsu_rd = 0; m_ack = 1; m_rtag = 11'h055;
      settle();
      checks++; if (aux_ack !== 1'b1 || lsu_ack !== 1'b0 || aux_rtag !== 11'h055) begin errors++; $display("FAIL lock_resp0: got aux=%0b lsu=%0b tag=%0h want aux 055", aux_ack, lsu_ack, aux_rtag); end
      tick();
      m_rtag = 11'h066;
      settle();
      checks++; if (lsu_ack !== 1'b1 || aux_ack !== 1'b0 || lsu_rtag !== 11'h066) begin errors++; $display("FAIL lock_resp1: got aux=%0b lsu=%0b tag=%0h want lsu 066", aux_ack, lsu_ack, lsu_rtag); end
      tick();
      m_ack = 0;
   endtask

   task automatic test_full();
      lsu_rd = 1; m_accept = 1;
      for (int i = 0; i < 4; i++) begin
         lsu_tag = 11'(11'h100 + i);
         settle();
         checks++; if (lsu_acc !== 1'b1) begin errors++; $display("FAIL full_fill[%0d]: got %0b want 1", i, lsu_acc); end
         tick();
      end
      lsu_tag = 11'h1FF; m_ack = 1;
      settle();
      checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_cnt: got %0d want 4", outstanding); end
      checks++; if (m_rd !== 1'b0 || lsu_acc !== 1'b0) begin errors++; $display("FAIL full_block: got rd=%0b acc=%0b want 0", m_rd, lsu_acc); end
      checks++; if (lsu_ack !== 1'b1) begin errors++; $display("FAIL full_ack: got %0b want 1", lsu_ack); end
      tick();
      m_ack = 0;
      settle();
      checks++; if (outstanding !== 3'd3 || lsu_acc !== 1'b1 || m_rd !== 1'b1) begin errors++; $display("FAIL full_after: got cnt=%0d acc=%0b rd=%0b want 3/1/1", outstanding, lsu_acc, m_rd); end
      tick();
      lsu_rd = 0; m_ack = 1;
      repeat (4) tick();
      m_ack = 0;
      settle();
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL full_drain: got %0d want 0", outstanding); end
      tick();
   endtask

   task automatic test_interleave();
      logic [3:0] src_aux = 4'b0110;
      m_accept = 1;
      for (int i = 0; i < 4; i++) begin
         lsu_rd = !src_aux[i]; aux_rd = src_aux[i];
         lsu_tag = 11'(17 * (i + 1)); aux_tag = 11'(17 * (i + 1));
         settle();
         checks++; if (aux_acc !== src_aux[i] || lsu_acc !== !src_aux[i]) begin errors++; $display("FAIL ilv_acc[%0d]: got aux=%0b lsu=%0b want aux=%0b", i, aux_acc, lsu_acc, src_aux[i]); end
         tick();
      end
      lsu_rd = 0; aux_rd = 0; m_accept = 0;
      for (int i = 0; i < 4; i++) begin
         m_ack = 1; m_rtag = 11'(17 * (i + 1)); m_rdata = 32'hA000_0000 + i;
         settle();
         if (src_aux[i]) begin
            checks++; if (aux_ack !== 1'b1 || lsu_ack !== 1'b0 || aux_rtag !== 11'(17 * (i + 1)) || lsu_rtag !== 11'h0) begin
               errors++; $display("FAIL ilv_resp[%0d]: got aux=%0b lsu=%0b atag=%0h ltag=%0h want aux", i, aux_ack, lsu_ack, aux_rtag, lsu_rtag); end
         end else begin
            checks++; if (lsu_ack !== 1'b1 || aux_ack !== 1'b0 || lsu_rtag !== 11'(17 * (i + 1)) || aux_rtag !== 11'h0) begin
               errors++; $display("FAIL ilv_resp[%0d]: got aux=%0b lsu=%0b atag=%0h ltag=%0h want lsu", i, aux_ack, lsu_ack, aux_rtag, lsu_rtag); end
         end
         tick();
      end
      m_ack = 0;
   endtask

   task automatic test_unexpected_and_reset();
      m_ack = 1; m_rdata = 32'h1234;
      settle();
      checks++; if (lsu_ack !== 1'b0 || aux_ack !== 1'b0) begin errors++; $display("FAIL unexp_ack: got aux=%0b lsu=%0b want 0", aux_ack, lsu_ack); end
      tick();
      m_ack = 0;
      settle();
      checks++; if (err_unexp !== 1'b1 || outstanding !== 3'd0) begin errors++; $display("FAIL unexp_err: got err=%0b cnt=%0d want 1/0", err_unexp, outstanding); end
      tick();
      lsu_rd = 1; m_accept = 1;
      repeat (2) tick();
      lsu_rd = 0; aux_rd = 1; m_accept = 0;
      tick();
      settle();
      checks++; if (outstanding !== 3'd2 || m_rd !== 1'b1) begin errors++; $display("FAIL rst_pre: got cnt=%0d rd=%0b want 2/1", outstanding, m_rd); end
      rst_n = 0;
      #1;
      checks++; if (outstanding !== 3'd0 || err_unexp !== 1'b0) begin errors++; $display("FAIL rst_async: got cnt=%0d err=%0b want 0/0", outstanding, err_unexp); end
      checks++; if (m_rd !== 1'b0 || aux_acc !== 1'b0) begin errors++; $display("FAIL rst_outs: got rd=%0b acc=%0b want 0", m_rd, aux_acc); end
      tick();
      rst_n = 1; aux_rd = 0; m_ack = 1;
      settle();
      checks++; if (lsu_ack !== 1'b0 || aux_ack !== 1'b0) begin errors++; $display("FAIL rst_stale: got aux=%0b lsu=%0b want 0", aux_ack, lsu_ack); end
      tick();
      m_ack = 0;
      settle();
      checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL rst_unexp: got %0b want 1", err_unexp); end
   endtask

   initial begin
      rst_n = 0;
      clear_inputs();
      tick();
      test_reset();
      tick();
      test_single_read();
      test_starvation();
      test_lock();
      test_full();
      test_interleave();
      test_unexpected_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
